// File: rtl/fetch_if.sv
// Bus between the fetch sequencer, instruction memory, execute redirect and decode.
// instr_valid/instr_ready: a transfer happens on a rising edge where both are 1; instr_valid
// never depends on instr_ready, and instr_out/instr_pc are stable while instr_valid=1 and instr_ready=0.
interface fetch_if;
    logic        en;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        br_taken;
    logic [31:0] br_target;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        halted;
    logic [15:0] fetch_count;
    logic [1:0]  fsm_state;

    modport master (
        input  en, imem_instr, br_taken, br_target, instr_ready,
        output imem_addr, instr_out, instr_pc, instr_valid, halted, fetch_count, fsm_state
    );

    modport slave (
        output en, imem_instr, br_taken, br_target, instr_ready,
        input  imem_addr, instr_out, instr_pc, instr_valid, halted, fetch_count, fsm_state
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, fills a 2-entry {pc, instr} buffer from IMEM,
// and handles branch redirects, decode backpressure and running off the end of IMEM.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 16
) (
    input logic     clk,
    input logic     reset,
    fetch_if.master bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HALT  = 2'd2
    } state_e;

    localparam logic [29:0] WORD_LIM = 30'(IMEM_WORDS);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        head_q, head_d;
    logic [31:0] buf_pc_q [2];
    logic [31:0] buf_pc_d [2];
    logic [31:0] buf_instr_q [2];
    logic [31:0] buf_instr_d [2];
    logic [15:0] fcnt_q, fcnt_d;

    logic pop, push, redirect, in_range, tail;

    assign pop      = (cnt_q != 2'd0) && bus.instr_ready;
    assign in_range = pc_q[31:2] < WORD_LIM;
    assign redirect = bus.br_taken && (state_q != S_IDLE);
    // Tail slot is head+count mod 2; when full this is the head slot being popped.
    assign tail     = head_q ^ cnt_q[0];

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        cnt_d       = cnt_q;
        head_d      = head_q;
        buf_pc_d    = buf_pc_q;
        buf_instr_d = buf_instr_q;
        fcnt_d      = fcnt_q;
        push        = 1'b0;

        if (redirect) begin
            cnt_d   = 2'd0;
            pc_d    = bus.br_target & ~32'h3;
            state_d = S_FETCH;
        end else begin
            unique case (state_q)
                S_IDLE:  if (bus.en) state_d = S_FETCH;
                S_FETCH: begin
                    if (!in_range) state_d = S_HALT;
                    else           push = bus.en && ((cnt_q != 2'd2) || pop);
                end
                S_HALT:  state_d = S_HALT;
                default: state_d = S_IDLE;
            endcase

            if (pop) head_d = ~head_q;
            if (push) begin
                buf_pc_d[tail]    = pc_q;
                buf_instr_d[tail] = bus.imem_instr;
                pc_d              = pc_q + 32'd4;
                if (fcnt_q != 16'hFFFF) fcnt_d = fcnt_q + 16'd1;
            end
            cnt_d = cnt_q + 2'(push) - 2'(pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            cnt_q   <= 2'd0;
            head_q  <= 1'b0;
            fcnt_q  <= 16'd0;
            for (int i = 0; i < 2; i++) begin
                buf_pc_q[i]    <= '0;
                buf_instr_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            cnt_q       <= cnt_d;
            head_q      <= head_d;
            fcnt_q      <= fcnt_d;
            buf_pc_q    <= buf_pc_d;
            buf_instr_q <= buf_instr_d;
        end
    end

    assign bus.imem_addr   = {2'b00, pc_q[31:2]};
    assign bus.instr_valid = (cnt_q != 2'd0);
    assign bus.instr_out   = bus.instr_valid ? buf_instr_q[head_q] : 32'd0;
    assign bus.instr_pc    = bus.instr_valid ? buf_pc_q[head_q] : 32'd0;
    assign bus.halted      = (state_q == S_HALT);
    assign bus.fetch_count = fcnt_q;
    assign bus.fsm_state   = state_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios with literal expectations, then random
// stimulus compared every cycle against a queue-based model of the fetch buffer.
module tb_fetch_sequencer;
    logic clk   = 1'b0;
    logic reset = 1'b1;

    fetch_if bus();

    fetch_sequencer #(.RESET_PC(32'h0000_0000), .IMEM_WORDS(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] imem [16];
    assign bus.imem_instr = (bus.imem_addr < 32'd16) ? imem[bus.imem_addr[3:0]] : 32'hDEAD_BEEF;

    // Model state: buffered {pc, instr} entries in order, fetch PC, run flags, push count.
    logic [63:0] mq[$];
    logic [31:0] m_pc      = 32'd0;
    bit          m_started = 1'b0;
    bit          m_halted  = 1'b0;
    logic [15:0] m_fc      = 16'd0;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc      = 32'd0;
        m_started = 1'b0;
        m_halted  = 1'b0;
        m_fc      = 16'd0;
    endtask

    task automatic model_step();
        bit pop, push;
        pop = (mq.size() > 0) && bus.instr_ready;
        if (!m_started) begin
            if (bus.en) m_started = 1'b1;
        end else if (bus.br_taken) begin
            mq.delete();
            m_pc     = bus.br_target & ~32'h3;
            m_halted = 1'b0;
        end else begin
            push = !m_halted && bus.en && ((m_pc >> 2) < 32'd16) && ((mq.size() < 2) || pop);
            if (!m_halted && ((m_pc >> 2) >= 32'd16)) m_halted = 1'b1;
            if (pop) void'(mq.pop_front());
            if (push) begin
                mq.push_back({m_pc, imem[m_pc[5:2]]});
                m_pc = m_pc + 32'd4;
                if (m_fc != 16'hFFFF) m_fc = m_fc + 16'd1;
            end
        end
    endtask

    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) model_reset();
        else       model_step();
    end

    initial forever begin
        @(negedge clk);
        if (check_en) begin
            check32("m_valid", 32'(bus.instr_valid), 32'(mq.size() > 0));
            if (mq.size() > 0) begin
                check32("m_instr_out", bus.instr_out, mq[0][31:0]);
                check32("m_instr_pc", bus.instr_pc, mq[0][63:32]);
            end
            check32("m_halted", 32'(bus.halted), 32'(m_halted));
            check32("m_fetch_count", 32'(bus.fetch_count), 32'(m_fc));
            check32("m_imem_addr", bus.imem_addr, {2'b00, m_pc[31:2]});
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #3;
        end
    endtask

    task automatic restart(input logic en_v, input logic ready_v);
        reset           = 1'b1;
        bus.en          = en_v;
        bus.instr_ready = ready_v;
        bus.br_taken    = 1'b0;
        step(2);
        reset = 1'b0;
    endtask

    logic [31:0] seq_words [4];

    initial begin
        bus.en          = 1'b0;
        bus.instr_ready = 1'b0;
        bus.br_taken    = 1'b0;
        bus.br_target   = 32'd0;
        seq_words[0] = 32'hE291_001B;
        seq_words[1] = 32'hE050_2101;
        seq_words[2] = 32'hE781_2002;
        seq_words[3] = 32'h0A00_0002;
        for (int i = 0; i < 16; i++) imem[i] = (i < 4) ? seq_words[i] : $urandom;

        step(2);
        check_en = 1'b1;
        check32("rst_valid", 32'(bus.instr_valid), 32'd0);
        check32("rst_halted", 32'(bus.halted), 32'd0);
        check32("rst_imem_addr", bus.imem_addr, 32'd0);
        check32("rst_instr_out", bus.instr_out, 32'd0);
        check32("rst_instr_pc", bus.instr_pc, 32'd0);
        check32("rst_fetch_count", 32'(bus.fetch_count), 32'd0);

        // Sequential fetch: first valid two edges after release, then one per cycle.
        bus.en = 1'b1;
        bus.instr_ready = 1'b1;
        reset = 1'b0;
        step(1);
        check32("seq_first_edge_valid", 32'(bus.instr_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step(1);
            check32("seq_valid", 32'(bus.instr_valid), 32'd1);
            check32("seq_pc", bus.instr_pc, 32'(i * 4));
            check32("seq_instr", bus.instr_out, seq_words[i]);
        end

        // End of memory, then redirect out of HALT.
        for (int i = 0; i < 40 && !bus.halted; i++) step(1);
        check32("eom_halted", 32'(bus.halted), 32'd1);
        check32("eom_fetch_count", 32'(bus.fetch_count), 32'd16);
        step(2);
        check32("eom_no_more_push", 32'(bus.fetch_count), 32'd16);
        bus.br_taken  = 1'b1;
        bus.br_target = 32'h4;
        step(1);
        bus.br_taken = 1'b0;
        check32("eom_br_halted", 32'(bus.halted), 32'd0);
        check32("eom_br_valid", 32'(bus.instr_valid), 32'd0);
        step(1);
        check32("eom_br_pc", bus.instr_pc, 32'h4);
        check32("eom_br_instr", bus.instr_out, 32'hE050_2101);

        // Backpressure from the start.
        restart(1'b1, 1'b0);
        step(4);
        check32("bp_valid", 32'(bus.instr_valid), 32'd1);
        check32("bp_head_pc", bus.instr_pc, 32'h0);
        check32("bp_imem_addr", bus.imem_addr, 32'd2);
        check32("bp_fetch_count", 32'(bus.fetch_count), 32'd2);
        step(2);
        check32("bp_addr_frozen", bus.imem_addr, 32'd2);
        check32("bp_head_held", bus.instr_out, 32'hE291_001B);
        bus.instr_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            step(1);
            check32("bp_drain_pc", bus.instr_pc, 32'(i * 4));
            check32("bp_drain_instr", bus.instr_out, seq_words[i]);
        end

        // Redirect while full to an unaligned target.
        restart(1'b1, 1'b0);
        step(4);
        check32("rd_full_pc", bus.instr_pc, 32'h0);
        bus.br_taken  = 1'b1;
        bus.br_target = 32'h0000_000E;
        step(1);
        bus.br_taken = 1'b0;
        check32("rd_flush_valid", 32'(bus.instr_valid), 32'd0);
        step(1);
        check32("rd_target_pc", bus.instr_pc, 32'hC);
        check32("rd_target_instr", bus.instr_out, 32'h0A00_0002);

        // Asynchronous reset mid-run takes effect before the next edge.
        reset = 1'b1;
        #1;
        check32("arst_valid", 32'(bus.instr_valid), 32'd0);
        check32("arst_halted", 32'(bus.halted), 32'd0);
        check32("arst_imem_addr", bus.imem_addr, 32'd0);
        step(1);

        // en toggling: fetch pauses at the held pc, buffer drains.
        bus.instr_ready = 1'b1;
        reset = 1'b0;
        step(5);
        bus.en = 1'b0;
        step(3);
        check32("en_fc_held", 32'(bus.fetch_count), 32'd4);
        check32("en_addr_held", bus.imem_addr, 32'd4);
        check32("en_drained", 32'(bus.instr_valid), 32'd0);
        bus.en = 1'b1;
        step(1);
        check32("en_resume_pc", bus.instr_pc, 32'h10);
        check32("en_resume_instr", bus.instr_out, imem[4]);

        // Random phase.
        for (int i = 0; i < 3000; i++) begin
            bus.en          = ($urandom_range(0, 9) != 0);
            bus.instr_ready = ($urandom_range(0, 2) != 0);
            bus.br_taken    = ($urandom_range(0, 19) == 0);
            bus.br_target   = 32'($urandom_range(0, 80));
            reset           = ($urandom_range(0, 299) == 0);
            step(1);
        end
        reset        = 1'b0;
        bus.br_taken = 1'b0;
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-fetch controller that owns the program counter and drives the 16-word combinational instruction memory's word address.
- Captures each returned instruction word, with its PC, into a 2-entry fetch buffer, presented to decode through a valid/ready handshake.
- Handles branch redirects (buffer flush plus PC reload), decode backpressure, and running off the end of instruction memory.

Parameters:
- RESET_PC, 32'h0000_0000: byte PC loaded on reset; bits [1:0] must be 0.
- IMEM_WORDS, 16: number of valid instruction words; word index range 0..IMEM_WORDS-1.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  fetch enable; 0 suspends fetching only, dequeue continues.
- imem_addr  out  32  word address to IMEM = {2'b00, pc[31:2]}; combinational from the pc register.
- imem_instr  in  32  instruction word from IMEM, valid in the same cycle as imem_addr.
- br_taken  in  1  single-cycle redirect request from execute.
- br_target  in  32  redirect byte address; bits [1:0] ignored and forced to 0.
- instr_out  out  32  instruction at buffer head.
- instr_pc  out  32  byte PC of instr_out.
- instr_valid  out  1  buffer non-empty.
- instr_ready  in  1  decode accepts head this cycle.
- halted  out  1  1 while in HALT.
- fetch_count  out  16  instructions pushed since reset; saturates at 16'hFFFF.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - pc=RESET_PC, state=IDLE, buffer count=0, fetch_count=0.
  - Outputs: instr_valid=0, halted=0, instr_out=0, instr_pc=0, imem_addr=RESET_PC>>2.
  - Reset mid-operation discards buffered instructions with no partial effect.
- FSM states: IDLE, FETCH, HALT.
  - IDLE: no push. Moves to FETCH on the first edge with en=1; that edge performs no push. br_taken is ignored in IDLE.
  - FETCH: push condition is en=1, pc word index < IMEM_WORDS, and (count<2 or pop in the same cycle). On a push:
    - the {pc, imem_instr} entry is written at the tail;
    - pc <= pc+4;
    - fetch_count increments, saturating.
  - FETCH, out of range: if pc word index >= IMEM_WORDS (and no br_taken), go to HALT with no push.
  - HALT: halted=1, no push; the buffer keeps draining normally. Exit only via br_taken or reset.
- Pop: occurs when instr_valid=1 and instr_ready=1; the head advances. Push and pop in the same cycle are legal at any count, including full (count stays 2).
- Redirect has priority over push and pop. On an edge with br_taken=1 in FETCH or HALT:
  - count <= 0, so any pop that cycle is discarded;
  - pc <= {br_target[31:2], 2'b00};
  - no push that cycle;
  - state <= FETCH, even if br_target is out of range. The out-of-range check then moves to HALT on the next edge.
- Priority order: reset > br_taken > push/pop.
- Latency:
  - Redirect edge to first valid target instruction: 1 edge, because the target is pushed on the edge after the redirect.
  - Reset release with en=1 to first instr_valid: 2 edges.
- Sustained throughput is 1 instruction/cycle with instr_ready=1. With instr_ready=0 the buffer fills after 2 pushes; pc then holds and imem_addr stays constant.
- en=0 in FETCH: pc holds and there is no push; the state stays FETCH.
- Arithmetic: pc+4 is 32-bit modulo, with no wrap to word 0; running past IMEM_WORDS-1 always goes to HALT.

Test Plan:
- Sequential fetch: IMEM words 0..3 = E291001B, E0502101, E7812002, 0A000002; en=1, ready=1 after reset -> instr_pc 0x0,0x4,0x8,0xC on consecutive cycles carrying those words in order; first valid 2 edges after reset release.
- Backpressure: ready=0 from start -> valid=1, count reaches 2 (pc 0x0, 0x4 held), pc=0x8, imem_addr=2 frozen; raise ready -> 0x0, 0x4, 0x8 delivered in order with no loss or duplication.
- Redirect while full: buffer holds 0x0 and 0x4, pulse br_taken with br_target=0x0000000E -> next cycle valid=0; the following cycle instr_pc=0xC, instr_out=0A000002.
- End of memory: en=1, ready=1, IMEM_WORDS=16 -> after PC 0x3C is pushed, halted=1 and fetch_count=16, with no further pushes; br_taken with target 0x4 -> halted=0 and instr_pc=0x4 follows.
- Reset mid-run: assert reset between edges while valid=1 -> instr_valid=0, halted=0, imem_addr=0 immediately, before the next edge.
- en toggling: en=0 for 3 cycles while in FETCH -> pc and fetch_count unchanged, buffer drains to empty; en=1 -> fetch resumes at the held pc.
